// File: rtl/irda_fir_rx_ctrl.sv
// irda_fir_rx_ctrl -- FIR receive sequencer.
//
// Arms the FIR receive datapath with restart pulses, supervises each frame
// (stop flag, decode error, RX FIFO overflow, inactivity), and queues a
// 20-bit status word per frame into a small first-word-fall-through FIFO
// read by the host. Each pushed word raises a one-clock interrupt.
//
// Status word: {tmo, ovf, rx_err, crc_err, length[15:0]}
//
// Ports:
//   clk, wb_rst_n_i       clock, asynchronous active-low reset
//   fir_rx4_enable        chip-rate tick enable; all timers count ticks
//   rx_en                 receiver enable; low forces IDLE
//   fir_sto_detected      stop flag seen
//   fir_rx_error          4PPM chip error / break
//   crc32_error           CRC result, sampled CRC_WAIT ticks after stop
//   fir_ifdlr_i           received byte length, sampled when reporting
//   rxfifo_add/full       RX FIFO push strobe and full flag
//   stat_pop              host pops the head status word
//   stat_ovf_clr          clears the sticky status-drop flag
//   fir_rx_restart        restart to the receive datapath
//   stat_dat_o/valid      head status word / FIFO non-empty
//   stat_ovf              sticky: a status word was dropped
//   irq_o                 one-clock pulse per pushed status word
//   frame_cnt/err_cnt     good/bad frame counters
//
// Optional build macro IRDA_FIR_RX_CTRL_CNT_EN: when defined, frame_cnt and
// err_cnt are saturating 16-bit counters of pushed words; otherwise both
// outputs are tied to zero.

module irda_fir_rx_ctrl #(
    parameter int unsigned STAT_AW       = 2,
    parameter int unsigned RESTART_TICKS = 4,
    parameter int unsigned CRC_WAIT      = 3,
    parameter int unsigned GAP_TICKS     = 256
) (
    input  logic        clk,
    input  logic        wb_rst_n_i,
    input  logic        fir_rx4_enable,
    input  logic        rx_en,
    input  logic        fir_sto_detected,
    input  logic        fir_rx_error,
    input  logic        crc32_error,
    input  logic [15:0] fir_ifdlr_i,
    input  logic        rxfifo_add,
    input  logic        rxfifo_full,
    input  logic        stat_pop,
    input  logic        stat_ovf_clr,
    output logic        fir_rx_restart,
    output logic [19:0] stat_dat_o,
    output logic        stat_valid,
    output logic        stat_ovf,
    output logic        irq_o,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RESTART = 3'd1;
    localparam logic [2:0] S_HUNT    = 3'd2;
    localparam logic [2:0] S_FRAME   = 3'd3;
    localparam logic [2:0] S_CHECK   = 3'd4;
    localparam logic [2:0] S_REPORT  = 3'd5;

    localparam int unsigned TMAX  = (RESTART_TICKS > CRC_WAIT) ? RESTART_TICKS : CRC_WAIT;
    localparam int unsigned TW    = $clog2(TMAX + 1);
    localparam int unsigned GW    = $clog2(GAP_TICKS + 1);
    localparam int unsigned DEPTH = 1 << STAT_AW;

    localparam logic [TW-1:0] RST_LAST = TW'(RESTART_TICKS - 1);
    localparam logic [TW-1:0] CRC_LAST = TW'(CRC_WAIT - 1);
    localparam logic [GW-1:0] GAP_LIM  = GW'(GAP_TICKS);

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [3:0]    flags_q, flags_d;   // {tmo, ovf, rx_err, crc_err}
    logic          restart_q;
    logic          report;
    logic          ev_err, ev_ovf, ev_sto, ev_tmo;

    logic [19:0]      mem_q [DEPTH];
    logic [STAT_AW:0] wr_ptr_q, rd_ptr_q;
    logic             irq_q, ovf_q;
    logic             fifo_empty, fifo_full, rd_en, wr_ok, drop;
    logic [19:0]      stat_word;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        gap_d   = gap_q;
        flags_d = flags_q;
        report  = 1'b0;
        ev_err  = 1'b0;
        ev_ovf  = 1'b0;
        ev_sto  = 1'b0;
        ev_tmo  = 1'b0;

        case (state_q)
            S_IDLE: begin
                tcnt_d  = '0;
                flags_d = '0;
                if (rx_en) state_d = S_RESTART;
            end
            S_RESTART: begin
                flags_d = '0;
                if (fir_rx4_enable) begin
                    if (tcnt_q == RST_LAST) begin
                        tcnt_d  = '0;
                        state_d = S_HUNT;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            S_HUNT: begin
                if (rxfifo_add) begin
                    gap_d   = '0;
                    state_d = S_FRAME;
                end
            end
            S_FRAME: begin
                if (rxfifo_add)          gap_d = '0;
                else if (fir_rx4_enable) gap_d = gap_q + 1'b1;

                ev_err = fir_rx_error;
                ev_ovf = rxfifo_add && rxfifo_full;
                ev_sto = fir_sto_detected;
                ev_tmo = (gap_d == GAP_LIM);

                // Every coincident event is recorded; only the exit is prioritised.
                if (ev_err || ev_ovf || ev_sto || ev_tmo)
                    flags_d = {ev_tmo, ev_ovf, ev_err, 1'b0};

                if (ev_err || ev_ovf) begin
                    state_d = S_REPORT;
                end else if (ev_sto) begin
                    tcnt_d  = '0;
                    state_d = S_CHECK;
                end else if (ev_tmo) begin
                    state_d = S_REPORT;
                end
            end
            S_CHECK: begin
                if (fir_rx4_enable) begin
                    if (tcnt_q == CRC_LAST) begin
                        flags_d[0] = crc32_error;
                        tcnt_d     = '0;
                        state_d    = S_REPORT;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            S_REPORT: begin
                report  = 1'b1;
                tcnt_d  = '0;
                state_d = S_RESTART;
            end
            default: state_d = S_IDLE;
        endcase

        // Dropping rx_en abandons the frame, including a pending report.
        if (!rx_en) begin
            state_d = S_IDLE;
            report  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q   <= S_IDLE;
            tcnt_q    <= '0;
            gap_q     <= '0;
            flags_q   <= '0;
            restart_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            gap_q     <= gap_d;
            flags_q   <= flags_d;
            // Registered so the output is low during reset yet tracks IDLE/RESTART.
            restart_q <= (state_d == S_IDLE) || (state_d == S_RESTART);
        end
    end

    assign fir_rx_restart = restart_q;

    // ------------------------------------------------------------------
    // Status FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    assign stat_word  = {flags_q, fir_ifdlr_i};
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[STAT_AW] != rd_ptr_q[STAT_AW]) &&
                        (wr_ptr_q[STAT_AW-1:0] == rd_ptr_q[STAT_AW-1:0]);
    assign rd_en      = stat_pop && !fifo_empty;
    // A same-cycle pop frees the slot being written.
    assign wr_ok      = report && (!fifo_full || rd_en);
    assign drop       = report && fifo_full && !rd_en;

    always_ff @(posedge clk or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_ok) begin
            mem_q[wr_ptr_q[STAT_AW-1:0]] <= stat_word;
        end
    end

    always_ff @(posedge clk or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            irq_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            irq_q <= wr_ok;
            if (drop)              ovf_q <= 1'b1;
            else if (stat_ovf_clr) ovf_q <= 1'b0;
        end
    end

    assign stat_dat_o = mem_q[rd_ptr_q[STAT_AW-1:0]];
    assign stat_valid = !fifo_empty;
    assign stat_ovf   = ovf_q;
    assign irq_o      = irq_q;

    // ------------------------------------------------------------------
    // Frame counters
    // ------------------------------------------------------------------
`ifdef IRDA_FIR_RX_CTRL_CNT_EN
    logic [15:0] frame_cnt_q, err_cnt_q;

    always_ff @(posedge clk or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else if (wr_ok) begin
            if (stat_word[19:16] == 4'd0) begin
                if (frame_cnt_q != '1) frame_cnt_q <= frame_cnt_q + 1'b1;
            end else begin
                if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
            end
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
`else
    assign frame_cnt = '0;
    assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_irda_fir_rx_ctrl.sv
// Directed bench for irda_fir_rx_ctrl. Inputs change and outputs are
// sampled on the falling clock edge; all expected values are hand-derived.

module tb_irda_fir_rx_ctrl;

`ifdef IRDA_FIR_RX_CTRL_CNT_EN
    localparam bit CNT = 1'b1;
`else
    localparam bit CNT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        wb_rst_n_i;
    logic        fir_rx4_enable;
    logic        rx_en;
    logic        fir_sto_detected;
    logic        fir_rx_error;
    logic        crc32_error;
    logic [15:0] fir_ifdlr_i;
    logic        rxfifo_add;
    logic        rxfifo_full;
    logic        stat_pop;
    logic        stat_ovf_clr;
    logic        fir_rx_restart;
    logic [19:0] stat_dat_o;
    logic        stat_valid;
    logic        stat_ovf;
    logic        irq_o;
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;

    int checks = 0;
    int errors = 0;
    bit div    = 1'b0;

    irda_fir_rx_ctrl #(
        .STAT_AW       (2),
        .RESTART_TICKS (4),
        .CRC_WAIT      (3),
        .GAP_TICKS     (256)
    ) dut (
        .clk              (clk),
        .wb_rst_n_i       (wb_rst_n_i),
        .fir_rx4_enable   (fir_rx4_enable),
        .rx_en            (rx_en),
        .fir_sto_detected (fir_sto_detected),
        .fir_rx_error     (fir_rx_error),
        .crc32_error      (crc32_error),
        .fir_ifdlr_i      (fir_ifdlr_i),
        .rxfifo_add       (rxfifo_add),
        .rxfifo_full      (rxfifo_full),
        .stat_pop         (stat_pop),
        .stat_ovf_clr     (stat_ovf_clr),
        .fir_rx_restart   (fir_rx_restart),
        .stat_dat_o       (stat_dat_o),
        .stat_valid       (stat_valid),
        .stat_ovf         (stat_ovf),
        .irq_o            (irq_o),
        .frame_cnt        (frame_cnt),
        .err_cnt          (err_cnt)
    );

    always #5 clk = ~clk;

    // Tick enable: every clock, or every other clock when div is set.
    initial begin
        fir_rx4_enable = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (div) fir_rx4_enable = ~fir_rx4_enable;
            else     fir_rx4_enable = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_irq(input int maxc, output int lat);
        lat = -1;
        for (int i = 1; i <= maxc; i++) begin
            @(negedge clk);
            if (irq_o) begin
                lat = i;
                break;
            end
        end
    endtask

    // Waits for HUNT (restart low), then delivers the first word of a frame.
    task automatic start_frame(input logic [15:0] len);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!fir_rx_restart) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("hunt_reached", {31'd0, found}, 32'd1);
        fir_ifdlr_i = len;
        rxfifo_add  = 1'b1;
        @(negedge clk);
        rxfifo_add  = 1'b0;
    endtask

    task automatic pop_one(input string tag, input logic [19:0] exp);
        chk(tag, {12'd0, stat_dat_o}, {12'd0, exp});
        stat_pop = 1'b1;
        @(negedge clk);
        stat_pop = 1'b0;
    endtask

    task automatic err_frame(input logic [15:0] len, output int lat);
        start_frame(len);
        fir_rx_error = 1'b1;
        @(negedge clk);
        fir_rx_error = 1'b0;
        wait_irq(10, lat);
    endtask

    initial begin
        int lat;
        int rc;
        bit seen;

        wb_rst_n_i       = 1'b0;
        rx_en            = 1'b1;
        fir_sto_detected = 1'b0;
        fir_rx_error     = 1'b0;
        crc32_error      = 1'b0;
        fir_ifdlr_i      = '0;
        rxfifo_add       = 1'b0;
        rxfifo_full      = 1'b0;
        stat_pop         = 1'b0;
        stat_ovf_clr     = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_restart", {31'd0, fir_rx_restart}, 32'd0);
        chk("rst_valid",   {31'd0, stat_valid},     32'd0);
        chk("rst_ovf",     {31'd0, stat_ovf},       32'd0);
        chk("rst_irq",     {31'd0, irq_o},          32'd0);
        chk("rst_dat",     {12'd0, stat_dat_o},     32'd0);
        chk("rst_fcnt",    {16'd0, frame_cnt},      32'd0);
        chk("rst_ecnt",    {16'd0, err_cnt},        32'd0);

        // Restart length counted in ticks, with a half-rate tick enable
        div        = 1'b1;
        wb_rst_n_i = 1'b1;
        rc   = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (fir_rx_restart) begin
                seen = 1'b1;
                if (fir_rx4_enable) rc++;
            end else if (seen) begin
                break;
            end
        end
        chk("restart_ticks", rc, 4);
        chk("restart_low",   {31'd0, fir_rx_restart}, 32'd0);
        div = 1'b0;
        @(negedge clk);

        // Good frame: length 32, CRC ok
        start_frame(16'd32);
        fir_sto_detected = 1'b1;
        @(negedge clk);
        fir_sto_detected = 1'b0;
        wait_irq(20, lat);
        chk("good_lat",     lat, 4);
        chk("good_dat",     {12'd0, stat_dat_o}, 32'h00020);
        chk("good_valid",   {31'd0, stat_valid}, 32'd1);
        chk("good_restart", {31'd0, fir_rx_restart}, 32'd1);
        chk("good_fcnt",    {16'd0, frame_cnt}, CNT ? 32'd1 : 32'd0);
        pop_one("good_pop", 20'h00020);
        chk("irq_pulse",    {31'd0, irq_o}, 32'd0);
        chk("good_empty",   {31'd0, stat_valid}, 32'd0);

        // CRC error frame
        crc32_error = 1'b1;
        start_frame(16'd32);
        fir_sto_detected = 1'b1;
        @(negedge clk);
        fir_sto_detected = 1'b0;
        wait_irq(20, lat);
        crc32_error = 1'b0;
        chk("crc_lat",  lat, 4);
        chk("crc_ecnt", {16'd0, err_cnt}, CNT ? 32'd1 : 32'd0);
        pop_one("crc_dat", 20'h10020);

        // Decode error, no CRC wait
        err_frame(16'd8, lat);
        chk("rxerr_lat", lat, 1);
        pop_one("rxerr_dat", 20'h20008);

        // Inactivity timeout
        start_frame(16'h0040);
        wait_irq(300, lat);
        chk("tmo_lat", lat, 257);
        pop_one("tmo_dat", 20'h80040);

        // RX FIFO overflow
        start_frame(16'd4);
        rxfifo_add  = 1'b1;
        rxfifo_full = 1'b1;
        @(negedge clk);
        rxfifo_add  = 1'b0;
        rxfifo_full = 1'b0;
        wait_irq(10, lat);
        chk("ovf_lat", lat, 1);
        pop_one("ovf_dat", 20'h40004);

        // rx_en dropped mid-frame: back to IDLE, nothing reported
        start_frame(16'd9);
        rx_en = 1'b0;
        @(negedge clk);
        rx_en = 1'b1;
        chk("abort_restart", {31'd0, fir_rx_restart}, 32'd1);
        wait_irq(20, lat);
        chk("abort_nopush", lat, -1);
        chk("abort_valid",  {31'd0, stat_valid}, 32'd0);

        // Pop while empty must not disturb the pointers
        stat_pop = 1'b1;
        @(negedge clk);
        stat_pop = 1'b0;
        chk("pop_empty", {31'd0, stat_valid}, 32'd0);

        // Fill the status FIFO, then drop one word
        for (int k = 1; k <= 4; k++) begin
            err_frame(16'(k), lat);
            chk("fill_lat", lat, 1);
        end
        err_frame(16'd5, lat);
        chk("drop_noirq", lat, -1);
        chk("drop_ovf",   {31'd0, stat_ovf},   32'd1);
        chk("drop_valid", {31'd0, stat_valid}, 32'd1);
        chk("drop_head",  {12'd0, stat_dat_o}, 32'h20001);

        // Pop and push in the same cycle while full
        start_frame(16'd6);
        fir_rx_error = 1'b1;
        @(negedge clk);
        fir_rx_error = 1'b0;
        stat_pop     = 1'b1;
        wait_irq(5, lat);
        stat_pop     = 1'b0;
        chk("pp_lat", lat, 1);
        chk("pp_ovf", {31'd0, stat_ovf}, 32'd1);
        pop_one("pp_w2", 20'h20002);
        pop_one("pp_w3", 20'h20003);
        pop_one("pp_w4", 20'h20004);
        pop_one("pp_w6", 20'h20006);
        chk("pp_empty", {31'd0, stat_valid}, 32'd0);

        stat_ovf_clr = 1'b1;
        @(negedge clk);
        stat_ovf_clr = 1'b0;
        chk("ovf_clr", {31'd0, stat_ovf}, 32'd0);

        // Counter totals, then asynchronous reset mid-frame
        err_frame(16'd7, lat);
        chk("last_lat", lat, 1);
        chk("fin_fcnt", {16'd0, frame_cnt}, CNT ? 32'd1 : 32'd0);
        chk("fin_ecnt", {16'd0, err_cnt},   CNT ? 32'd10 : 32'd0);
        start_frame(16'd11);
        #2;
        wb_rst_n_i = 1'b0;
        #1;
        chk("arst_valid",   {31'd0, stat_valid},     32'd0);
        chk("arst_dat",     {12'd0, stat_dat_o},     32'd0);
        chk("arst_restart", {31'd0, fir_rx_restart}, 32'd0);
        chk("arst_ecnt",    {16'd0, err_cnt},        32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
